uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter that consumes bytes written by the CPU core and serialises them onto uo_out[4].
- Replaces the constant-idle uart_tx tie-off in the top level.
- A small FIFO decouples CPU store timing, including mem_ready stalls, from the serial line rate.
- Write side is a single-cycle strobe driven from the CPU store path; the caller gates the strobe with mem_ready.

Parameters:
- CLK_DIV, 104, clock cycles per serial bit (12 MHz / 115200 baud); legal range 2..65535.
- FIFO_DEPTH, 4, number of byte entries; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- wr_en  input  1  push wr_data this cycle; already qualified with mem_ready by the caller.
- wr_data  input  8  byte to transmit.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when wr_en is asserted while full and no pop occurs in the same cycle.

Behaviour:
- Reset is one clock, asynchronous and active-high. The reset values are:
  - tx=1, busy=0, fifo_full=0, fifo_empty=1, level=0, overflow=0.
  - FSM in IDLE; baud counter and bit index cleared.
  - FIFO pointers cleared; FIFO data contents are don't-care.
- Reset asserted mid-frame aborts the frame immediately. tx returns high asynchronously and no partial byte is resumed.
- FSM states are IDLE, START, DATA, PARITY (optional), STOP.
  - IDLE: tx=1. On an edge where the FIFO is non-empty:
    - pop the head entry into the shift register;
    - go to START, set tx<=0, set baud_cnt<=0.
  - START, DATA, PARITY and STOP each last exactly CLK_DIV cycles. baud_cnt counts 0..CLK_DIV-1; the bit boundary is baud_cnt==CLK_DIV-1.
  - START -> DATA. DATA drives 8 bits, LSB first; bit index runs 0..7 and the shift register shifts right at each boundary.
  - DATA at bit 7 boundary -> STOP (or PARITY when the optional feature is enabled). STOP drives tx=1.
  - STOP boundary with FIFO non-empty: pop and go directly to START on the same edge. Frames are back-to-back with no idle cycle.
  - STOP boundary with FIFO empty: go to IDLE.
- Frame length is 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
- Latency: wr_en sampled at edge N into an empty FIFO in IDLE -> fifo_empty low after N -> pop at edge N+1 -> tx low after edge N+1.
- tx is a registered output; glitch-free.
- FIFO rules:
  - Circular buffer with an extra wrap bit on each pointer; level = wr_ptr - rd_ptr.
  - Write while full is dropped, unless a pop happens on the same edge, in which case the write is accepted and level stays constant.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves level unchanged.
  - Push to an empty FIFO at the same edge the FSM checks emptiness: the byte is not visible until the next edge (no bypass).
- overflow clears only on rst.
- wr_data is ignored when wr_en=0.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits), latched at pop time, for CLK_DIV cycles.
  - Frame becomes 8E1, 11 bit times.
- When undefined: no PARITY state and no parity register; frame is 8N1.

Decomposition:
- defines.vh holds:
  - FSM state encodings UART_IDLE, UART_START, UART_DATA, UART_PARITY, UART_STOP (3-bit);
  - UART_DEFAULT_CLK_DIV.
- The natural sub-module is uart_fifo, a synchronous FIFO with parameter DEPTH and ports clk, rst, push, din, pop, dout, full, empty, level. It is instantiated once.
- Baud counter and FSM stay in uart_tx_fifo.

Test Plan:
- Reset then idle, CLK_DIV=4: hold 100 cycles -> tx=1, busy=0, fifo_empty=1, level=0.
- Single byte 0x55 written at edge N -> tx=0 from N+1 for 4 cycles; then bits 1,0,1,0,1,0,1,0 (4 cycles each); then stop=1; busy falls 40 cycles after N+1.
- Burst of 4 writes (0xA5, 0x01, 0xFF, 0x80) on consecutive cycles:
  - level peaks at 3, fifo_full never set, since the first pop coincides with the 2nd write;
  - 4 contiguous frames with no idle gap;
  - decoded bytes match in order.
- Overflow: 6 writes on consecutive cycles while the first frame is in progress, FIFO_DEPTH=4 -> 4 accepted, remaining dropped, overflow=1 sticky until rst; only accepted bytes are transmitted.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C -> tx=1 immediately; after release, no residual frame; a new write of 0x42 transmits cleanly.
- UART_PARITY_EN defined: send 0x07 -> parity bit 1 and 11-bit frame; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// FSM encodings are plain 3-bit localparams so older tools can consume them.
package uart_tx_fifo_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [2:0] UART_IDLE   = 3'd0;
    localparam logic [2:0] UART_START  = 3'd1;
    localparam logic [2:0] UART_DATA   = 3'd2;
    localparam logic [2:0] UART_PARITY = 3'd3;
    localparam logic [2:0] UART_STOP   = 3'd4;

    localparam int UART_DEFAULT_CLK_DIV = 104;

    function automatic logic even_par(input byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO: circular buffer whose pointers carry an extra wrap bit.
// A write while full is accepted only when a pop happens on the same edge.
module uart_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  byte_t       din,
    input  logic        pop,
    output byte_t       dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    byte_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_W);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; occupancy comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter, 8N1 (8E1 when UART_PARITY_EN is defined).
// Bytes are queued in uart_fifo and sent back-to-back from the FSM below.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          tx,
    output logic          busy,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [LW-1:0] level,
    output logic          overflow
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    byte_t       shreg;
    byte_t       head;
    logic        pop;
    logic        boundary;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign boundary = (baud_cnt == DIV_LAST);
    assign busy     = (state != UART_IDLE);
    assign pop      = !fifo_empty &&
                      ((state == UART_IDLE) ||
                       (state == UART_STOP && boundary));

`ifdef UART_PARITY_EN
    logic parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      parity <= 1'b0;
        else if (pop) parity <= even_par(head);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (wr_en && fifo_full && !pop)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (pop) begin
            // Covers both the idle start and a back-to-back frame.
            shreg    <= head;
            state    <= UART_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
        end else if (state != UART_IDLE) begin
            if (!boundary) begin
                baud_cnt <= baud_cnt + 16'd1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    UART_START: begin
                        state   <= UART_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                    UART_DATA: begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= UART_PARITY;
                            tx    <= parity;
`else
                            state <= UART_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
`ifdef UART_PARITY_EN
                    UART_PARITY: begin
                        state <= UART_STOP;
                        tx    <= 1'b1;
                    end
`endif
                    default: begin
                        state <= UART_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, serial decoder,
// and directed tests. Define UART_PARITY_EN to exercise 8E1 framing.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: queue of accepted bytes plus position within current frame.
    logic [7:0] mq[$];
    int         mt = -1;
    logic [7:0] mcur = '0;
    logic       movf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mt   = -1;
            movf = 1'b0;
        end else begin
            if (mt >= 0) begin
                mt++;
                if (mt == NB * DIV) mt = -1;
            end
            if (mt < 0 && mq.size() > 0) begin
                mcur = mq.pop_front();
                mt   = 0;
            end
            if (wr_en) begin
                if (mq.size() < DEPTH) mq.push_back(wr_data);
                else movf = 1'b1;
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        if (mt < 0) return 1'b1;
        k = mt / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return mcur[k-1];
        if (NB == 11 && k == 9) return ^mcur;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        chk("m_tx", 32'(tx), 32'(exp_tx()));
        chk("m_busy", 32'(busy), 32'(mt >= 0));
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
        chk("m_empty", 32'(fifo_empty), 32'(mq.size() == 0));
        chk("m_ovf", 32'(overflow), 32'(movf));
    end

    // Serial decoder sampling mid-bit.
    logic [7:0]  rx_q[$];
    logic        rxp_q[$];
    logic [10:0] rx_bits = '0;
    int          rx_cnt = -1;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt = -1;
        end else begin
            if (rx_cnt < 0) begin
                if (tx == 1'b0) rx_cnt = 0;
            end else begin
                rx_cnt++;
            end
            if (rx_cnt >= 0 && rx_cnt % DIV == DIV / 2) begin
                rx_bits[rx_cnt / DIV] = tx;
                if (rx_cnt / DIV == NB - 1) begin
                    rx_q.push_back(rx_bits[8:1]);
                    rxp_q.push_back(rx_bits[9]);
                    rx_cnt = -1;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'hxx;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !fifo_empty) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 2000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] e[$]);
        chk({nm, "_count"}, 32'(rx_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < rx_q.size())
                chk({nm, "_byte"}, 32'(rx_q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        logic [10:0] frame55;
`ifdef UART_PARITY_EN
        frame55 = 11'b100_1010_1010;
`else
        frame55 = 11'b010_1010_1010;
`endif
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        repeat (100) @(posedge clk);
        #1;
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_empty", 32'(fifo_empty), 32'd1);
        chk("idle_level", 32'(level), 32'd0);

        // Single byte 0x55, bit-exact waveform.
        rx_q.delete();
        rxp_q.delete();
        push(8'h55);
        chk("s_empty_after_wr", 32'(fifo_empty), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < DIV; c++) begin
                chk("s55_bit", 32'(tx), 32'(frame55[k]));
                chk("s55_busy", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        chk("s55_busy_fall", 32'(busy), 32'd0);
        chk("s55_tx_idle", 32'(tx), 32'd1);
        wait_idle();
        chk_rx("s55", '{8'h55});

        // Burst of 4: first pop overlaps second write.
        rx_q.delete();
        rxp_q.delete();
        push(8'hA5);
        push(8'h01);
        push(8'hFF);
        push(8'h80);
        chk("burst_level", 32'(level), 32'd3);
        chk("burst_full", 32'(fifo_full), 32'd0);
        wait_idle();
        chk_rx("burst", '{8'hA5, 8'h01, 8'hFF, 8'h80});

        // Overflow: 6 writes while a frame runs.
        rx_q.delete();
        rxp_q.delete();
        push(8'h11);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        wait_idle();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk_rx("ovf", '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24});

        // Reset during DATA bit 3 of 0x3C.
        rx_q.delete();
        rxp_q.delete();
        push(8'h3C);
        repeat (18) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_tx_async", 32'(tx), 32'd1);
        chk("mid_busy_async", 32'(busy), 32'd0);
        chk("mid_ovf_clear", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_q.delete();
        rxp_q.delete();
        repeat (60) @(posedge clk);
        #1;
        chk("mid_no_residual", 32'(rx_q.size()), 32'd0);
        chk("mid_tx_high", 32'(tx), 32'd1);
        push(8'h42);
        wait_idle();
        chk_rx("after_rst", '{8'h42});

`ifdef UART_PARITY_EN
        rx_q.delete();
        rxp_q.delete();
        push(8'h07);
        wait_idle();
        chk_rx("par07", '{8'h07});
        if (rxp_q.size() > 0) chk("par07_bit", 32'(rxp_q[0]), 32'd1);
        rx_q.delete();
        rxp_q.delete();
        push(8'h03);
        wait_idle();
        chk_rx("par03", '{8'h03});
        if (rxp_q.size() > 0) chk("par03_bit", 32'(rxp_q[0]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
